mdio_master: RTL

Clause-22 MDIO management master that lets on-chip control logic read and write the Ethernet PHY's registers over eth_mdc/eth_mdio. It sits between the design's control logic and the top-level eth_mdio/eth_mdc pins, beside the SGMII PCS/PMA. It accepts one register request at a time and serialises it into a 64-bit MDIO frame. It returns read data and a no-response flag through a single-cycle response strobe.

---
 rtl/mdio_pkg.sv | 26 ++
 rtl/mdio_clk_gen.sv | 47 ++++
 rtl/mdio_master.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdio_pkg
// Brief    : Shared state encoding and Clause-22 frame constants for mdio_master
// Revision : 1.0
// ============================================================================
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4,
        S_TRAIL    = 3'd5
    } mdio_state_t;

    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] ST_BITS     = 2'b01;
    localparam logic [1:0] TA_WRITE    = 2'b10;
    localparam int         HEADER_BITS = 14;
    localparam int         DATA_BITS   = 16;

endpackage
`default_nettype wire

// File: rtl/mdio_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : mdio_clk_gen
// Brief    : MDC divider; strobes flag the cycle on which MDC will rise or fall
// Revision : 1.0
// ============================================================================
module mdio_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    input  logic i_run,
    output logic o_mdc,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam logic [9:0] c_DIV_LAST = 10'(CLK_DIV - 1);

    logic [9:0] r_cnt;
    logic       r_mdc;
    logic       w_wrap;

    assign w_wrap = i_run && !i_restart && (r_cnt == c_DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 10'd0;
            r_mdc <= 1'b0;
        end else if (i_restart || !i_run) begin
            r_cnt <= 10'd0;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= 10'd0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    assign o_mdc      = r_mdc;
    assign o_rise_stb = w_wrap && !r_mdc;
    assign o_fall_stb = w_wrap &&  r_mdc;

endmodule
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : mdio_master
// Brief    : Clause-22 MDIO master; one request at a time, 64-bit frame + trail.
//            Optional MDIO_PREAMBLE_SUPPRESS_EN drops the preamble after the
//            first frame following reset.
// Revision : 1.0
// ============================================================================
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [9:0] c_PRE_LAST  = 10'(PREAMBLE_LEN - 1);
    localparam logic [9:0] c_HDR_LAST  = 10'(HEADER_BITS - 1);
    localparam logic [9:0] c_TA_LAST   = 10'd1;
    localparam logic [9:0] c_DATA_LAST = 10'(DATA_BITS - 1);

    mdio_state_t r_state;
    logic [9:0]  r_bit_cnt;
    logic [31:0] r_tx;
    logic        r_write;
    logic [15:0] r_rx;
    logic        r_ta_err;
    logic        r_sync1, r_sync2;
    logic        r_mdio_o, r_mdio_oe;
    logic        r_req_ready, r_rsp_valid, r_rsp_error;
    logic [15:0] r_rsp_rdata;
    logic        w_accept, w_rise, w_fall, w_skip_pre, w_run;

    assign w_accept = req_valid && r_req_ready;
    assign w_run    = (r_state != S_IDLE);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic r_first;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_first <= 1'b1;
        else if (w_accept) r_first <= 1'b0;
    end

    assign w_skip_pre = (PREAMBLE_LEN == 0) || !r_first;
`else
    assign w_skip_pre = (PREAMBLE_LEN == 0);
`endif

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clock      (clock),
        .reset      (reset),
        .i_restart  (w_accept),
        .i_run      (w_run),
        .o_mdc      (mdc),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= mdio_i;
            r_sync2 <= r_sync1;
        end
    end

    // r_tx[31] is the bit on the wire; r_tx[30] is the one driven at the next MDC fall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 10'd0;
            r_tx        <= 32'd0;
            r_write     <= 1'b0;
            r_rx        <= 16'd0;
            r_ta_err    <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_tx        <= {ST_BITS, (req_write ? OP_WRITE : OP_READ),
                                        req_phy_addr, req_reg_addr, TA_WRITE,
                                        (req_write ? req_wdata : 16'd0)};
                        r_req_ready <= 1'b0;
                        r_bit_cnt   <= 10'd0;
                        r_ta_err    <= 1'b0;
                        r_mdio_oe   <= 1'b1;
                        if (w_skip_pre) begin
                            r_state  <= S_HEADER;
                            r_mdio_o <= ST_BITS[1];
                        end else begin
                            r_state  <= S_PREAMBLE;
                            r_mdio_o <= 1'b1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (w_fall) begin
                        if (r_bit_cnt == c_PRE_LAST) begin
                            r_state   <= S_HEADER;
                            r_bit_cnt <= 10'd0;
                            r_mdio_o  <= r_tx[31];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 10'd1;
                        end
                    end
                end
                S_HEADER: begin
                    if (w_fall) begin
                        r_tx <= r_tx << 1;
                        if (r_bit_cnt == c_HDR_LAST) begin
                            r_state   <= S_TA;
                            r_bit_cnt <= 10'd0;
                            r_mdio_o  <= r_write ? r_tx[30] : 1'b1;
                            r_mdio_oe <= r_write;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 10'd1;
                            r_mdio_o  <= r_tx[30];
                        end
                    end
                end
                S_TA: begin
                    if (w_rise && (r_bit_cnt == c_TA_LAST)) begin
                        r_ta_err <= r_sync2;
                    end
                    if (w_fall) begin
                        r_tx     <= r_tx << 1;
                        r_mdio_o <= r_write ? r_tx[30] : 1'b1;
                        if (r_bit_cnt == c_TA_LAST) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 10'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 10'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[14:0], r_sync2};
                    end
                    if (w_fall) begin
                        r_tx <= r_tx << 1;
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_state   <= S_TRAIL;
                            r_bit_cnt <= 10'd0;
                            r_mdio_o  <= 1'b1;
                            r_mdio_oe <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 10'd1;
                            r_mdio_o  <= r_write ? r_tx[30] : 1'b1;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_fall) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_write ? 16'd0 : r_rx;
                        r_rsp_error <= !r_write && r_ta_err;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign mdio_o    = r_mdio_o;
    assign mdio_oe   = r_mdio_oe;

endmodule
`default_nettype wire
